irq_ctrl: RTL

//  Interrupt controller feeding the main decoder's EXL/IV inputs: latches edges from timer flag,

---
 rtl/irq_ctrl_pkg.sv | 12 +
 rtl/irq_ctrl_if.sv | 9 +
 rtl/irq_prio_enc.sv | 15 +
 rtl/irq_ctrl.sv | 71 +++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared FSM state encoding, register map and default vector base for irq_ctrl.
package irq_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;
  localparam logic [4:0]  ADDR_MASK    = 5'b11000;
  localparam logic [4:0]  ADDR_PENDING = 5'b11001;
  localparam logic [4:0]  ADDR_STATUS  = 5'b11010;
  localparam logic [31:0] VEC_BASE_DEF = 32'h180;
endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: memory-mapped register bus shared with the timer (write strobe, address, data in/out).
interface irq_ctrl_if;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;
  modport master (output we, addr, wd, input rd);
  modport slave (input we, addr, wd, output rd);
endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational lowest-index priority encoder.
module irq_prio_enc #(
  parameter int NSRC = 4,
  parameter int ID_W = 2
) (
  input  logic [NSRC-1:0] i_req,
  output logic [ID_W-1:0] o_id,
  output logic            o_any
);
  always_comb begin
    o_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) o_id = i_req[i] ? ID_W'(i) : o_id;
  end
  assign o_any = |i_req;
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-latching, masked, prioritised interrupt controller with ack/done handshake.
// Define IRQ_VECTOR_EN for per-source vectored handler addresses and the iv indicator.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          NSRC       = 4,
  parameter int          ID_W       = 2,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [31:0] VEC_STRIDE = 32'h8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NSRC-1:0]  irq,
  irq_ctrl_if.slave        bus,
  input  logic             int_ack,
  input  logic             int_done,
  output logic             exl,
  output logic             iv,
  output logic [ID_W-1:0]  int_id,
  output logic [31:0]      int_vec
);
  state_t          r_state, w_next;
  logic [NSRC-1:0] r_irq_q, r_pend, r_mask, w_set, w_clr;
  logic [ID_W-1:0] r_int_id, w_id;
  logic            w_any, w_wr_mask, w_wr_pend, w_done, w_unused;
  irq_prio_enc #(.NSRC(NSRC), .ID_W(ID_W)) u_enc (
    .i_req (r_pend & r_mask),
    .o_id  (w_id),
    .o_any (w_any)
  );
  assign w_set     = irq & ~r_irq_q;
  assign w_wr_mask = bus.we && bus.addr == ADDR_MASK;
  assign w_wr_pend = bus.we && bus.addr == ADDR_PENDING;
  assign w_done    = r_state == SERVICE && int_done;
  assign w_clr     = (w_wr_pend ? bus.wd[NSRC-1:0] : '0) | (w_done ? NSRC'(1) << r_int_id : '0);
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE && w_any)    ? REQ     :
             (r_state == REQ && int_ack)   ? SERVICE :
             w_done                        ? IDLE    : r_state;
  end
  // new edges are OR-ed in after clearing so a same-cycle set always wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_irq_q  <= '0;
      r_pend   <= '0;
      r_mask   <= '0;
      r_int_id <= '0;
    end else begin
      r_state <= w_next;
      r_irq_q <= irq;
      r_pend  <= (r_pend & ~w_clr) | w_set;
      if (w_wr_mask) r_mask <= bus.wd[NSRC-1:0];
      if (r_state == IDLE && w_any) r_int_id <= w_id;
    end
  end
  assign bus.rd = bus.addr == ADDR_MASK    ? 32'(r_mask) :
                  bus.addr == ADDR_PENDING ? 32'(r_pend) :
                  bus.addr == ADDR_STATUS  ? 32'({r_state, r_int_id}) : '0;
  assign exl    = r_state == REQ;
  assign int_id = r_int_id;
`ifdef IRQ_VECTOR_EN
  assign iv      = exl;
  assign int_vec = VEC_BASE + 32'(r_int_id) * VEC_STRIDE;
`else
  assign iv      = 1'b0;
  assign int_vec = VEC_BASE;
`endif
  assign w_unused = ^{bus.wd, VEC_STRIDE};
endmodule
